// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller: state encoding and block geometry.
package cache_fill_fsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int unsigned WORDS_PER_BLOCK   = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_IDX_W        = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W             = WORD_IDX_W + 1;

endpackage

// File: rtl/fill_counter.sv
// Word counter with synchronous clear and count enable; one extra bit so "all words done" is representable.
module fill_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss fill controller: issues the eight word reads of a block, streams returns into the
// data array, and commits the tag on the last returned word.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [DATA_WIDTH-1:0] memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  memory_enable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [DATA_WIDTH-1:0] fill_data
);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);
    localparam logic [CNT_W-1:0]      LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]      ALL_WORDS   = CNT_W'(WORDS_PER_BLOCK);

    fill_state_t           state;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      recv_cnt;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  in_fill;
    logic                  start;
    logic                  recv_en;
    logic                  done;

    assign in_fill       = (state == FILL);
    assign start         = (state == IDLE) && miss_detected;
    assign memory_enable = in_fill && (issue_cnt < ALL_WORDS);
    // Returns outside FILL are stale and dropped.
    assign recv_en       = in_fill && memory_data_valid;
    assign done          = recv_en && (recv_cnt == LAST_WORD);

    assign fsm_busy         = in_fill;
    assign write_data_array = recv_en;
    assign write_tag_array  = done;
    assign fill_word        = recv_en ? recv_cnt[WORD_IDX_W-1:0] : '0;
    assign fill_data        = memory_data;
    assign memory_address   = memory_enable
                            ? (base_addr | ADDR_WIDTH'({issue_cnt[WORD_IDX_W-1:0], 1'b0}))
                            : base_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_addr <= miss_address & ~OFFSET_MASK;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (memory_enable),
        .count  (issue_cnt)
    );

    fill_counter #(.WIDTH(CNT_W)) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (recv_en),
        .count  (recv_cnt)
    );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: expected requests and array writes are queued as stimulus is driven.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;

    typedef struct {
        logic [2:0]  word;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] addr_q[$];
    int          sched[8];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_enable     (memory_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle 0 presents the miss; valid k is returned in cycle sched[k]; rst_c < 0 means no reset.
    task automatic run_fill(input logic [15:0] addr, input int rst_c, input bit hold, input int ncyc);
        int end_c;
        int busy_cnt;
        end_c    = (rst_c >= 0) ? rst_c : sched[7];
        busy_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            int          k;
            bit          vld;
            bit          active;
            bit          exp_en;
            wr_t         w;
            logic [15:0] ea;
            @(negedge clk);
            k = -1;
            for (int i = 0; i < 8; i++) if (sched[i] == c) k = i;
            vld               = (k >= 0);
            active            = (c >= 1) && (c <= end_c);
            exp_en            = active && (c <= 8);
            rst               = (c == rst_c);
            miss_detected     = (c == 0) || (hold && c <= end_c);
            miss_address      = addr;
            memory_data_valid = vld;
            memory_data       = vld ? (16'hA000 + 16'(k)) : 16'($urandom);
            if (exp_en) addr_q.push_back((addr & 16'hFFF0) | 16'((c - 1) * 2));
            if (vld && active) wr_q.push_back('{word: 3'(k), data: 16'hA000 + 16'(k)});
            #1;
            check("fsm_busy", 32'(fsm_busy), 32'(active));
            check("memory_enable", 32'(memory_enable), 32'(exp_en));
            check("write_data_array", 32'(write_data_array), 32'(vld && active));
            check("write_tag_array", 32'(write_tag_array), 32'(vld && active && k == 7));
            if (fsm_busy) busy_cnt++;
            if (memory_enable) begin
                if (addr_q.size() == 0) check("addr_q_underflow", 32'(1), 32'(0));
                else begin
                    ea = addr_q.pop_front();
                    check("memory_address", 32'(memory_address), 32'(ea));
                end
            end
            if (write_data_array) begin
                if (wr_q.size() == 0) check("wr_q_underflow", 32'(1), 32'(0));
                else begin
                    w = wr_q.pop_front();
                    check("fill_word", 32'(fill_word), 32'(w.word));
                    check("fill_data", 32'(fill_data), 32'(w.data));
                end
            end
            if (rst_c >= 0 && c == rst_c + 1) begin
                check("post_reset_address", 32'(memory_address), 32'(0));
                check("post_reset_fill_word", 32'(fill_word), 32'(0));
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'(end_c));
        check("addr_q_drained", 32'(addr_q.size()), 32'(0));
        check("wr_q_drained", 32'(wr_q.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data       = 16'h5A5A;
        memory_data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_busy", 32'(fsm_busy), 32'(0));
        check("reset_enable", 32'(memory_enable), 32'(0));
        check("reset_address", 32'(memory_address), 32'(0));
        check("reset_wda", 32'(write_data_array), 32'(0));
        check("reset_wta", 32'(write_tag_array), 32'(0));
        check("reset_fill_word", 32'(fill_word), 32'(0));
        check("reset_fill_data", 32'(fill_data), 32'(16'h5A5A));

        // Stale returns while idle must not write.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            memory_data_valid = 1'b1;
            memory_data       = 16'hBEEF;
            #1;
            check("idle_valid_wda", 32'(write_data_array), 32'(0));
            check("idle_valid_busy", 32'(fsm_busy), 32'(0));
        end

        sched = '{5, 6, 7, 8, 9, 10, 11, 12};
        run_fill(16'h1236, -1, 1'b0, 14);

        sched = '{5, 6, 9, 10, 11, 14, 15, 16};
        run_fill(16'h4A52, -1, 1'b0, 18);

        sched = '{5, 6, 7, 9, 10, 11, 12, 13};
        run_fill(16'h2222, 8, 1'b0, 16);

        sched = '{5, 6, 7, 8, 9, 10, 11, 12};
        run_fill(16'h2222, -1, 1'b0, 14);

        sched = '{5, 6, 7, 8, 9, 10, 11, 12};
        run_fill(16'h3338, -1, 1'b1, 13);
        run_fill(16'hFFF0, -1, 1'b0, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller on the memory side of the 2-way set-associative I/D cache.
- On a sampled `miss_detected`, it fetches the 16-byte block (8 × 16-bit words) containing `miss_address` from the pipelined multi-cycle main memory.
- It streams each returned word into the cache data array, then commits the tag/valid/LRU metadata with a one-cycle `write_tag_array` pulse.
- The pipeline stalls on `fsm_busy`.

Parameters:
- `DATA_WIDTH`, 16, width of a memory word and of the cache data port.
- `ADDR_WIDTH`, 16, byte address width.
- `WORDS_PER_BLOCK`, 8, words per cache block; fixed at a power of two; counters are `$clog2(WORDS_PER_BLOCK)`+1 bits wide.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `miss_detected` input 1 — cache reports a miss on the current access.
- `miss_address` input `ADDR_WIDTH` — byte address of the missing access.
- `memory_data` input `DATA_WIDTH` — read data from main memory.
- `memory_data_valid` input 1 — `memory_data` holds a returned word this cycle.
- `fsm_busy` output 1 — fill in progress; pipeline must stall.
- `memory_enable` output 1 — issue a read request to memory this cycle.
- `memory_address` output `ADDR_WIDTH` — byte address of the issued request.
- `write_data_array` output 1 — write `fill_data` into the cache word `fill_word`.
- `write_tag_array` output 1 — commit the metadata for the filled block.
- `fill_word` output 3 — word index within the block for the current data write.
- `fill_data` output `DATA_WIDTH` — data for the cache array; equals `memory_data`.

Behaviour:
- Reset (`rst`=1 at a rising edge):
  - state←IDLE, `issue_cnt`←0, `recv_cnt`←0, `base_addr`←0.
  - Every output reads 0 in the following cycle, except `fill_data`, which mirrors `memory_data`.
  - A reset during FILL abandons the fill: no further request is issued and `write_tag_array` does not fire. Words already written remain in the data array with their old tag, which is harmless.
- States: IDLE, FILL. Encoding is 1 bit.
- IDLE:
  - `fsm_busy`=0, `memory_enable`=0, `write_data_array`=0, `write_tag_array`=0.
  - `memory_data_valid` is ignored, so stale returns are dropped.
  - If `miss_detected`=1 at an edge: `base_addr`←{`miss_address`[15:4], 4'b0}, both counters←0, state←FILL.
- FILL:
  - `fsm_busy`=1.
  - `miss_detected` is ignored; the pipeline is frozen, so the miss stays asserted.
- Request issue:
  - `memory_enable`=1 while `issue_cnt`<8.
  - `memory_address`={`base_addr`[15:4], `issue_cnt`[2:0], 1'b0}.
  - `issue_cnt` increments each FILL cycle until it saturates at 8.
  - When `memory_enable`=0, `memory_address`=`base_addr`, which is don't-care to memory.
  - Eight back-to-back requests go out in the first 8 FILL cycles, words 0..7 in order.
- Data return:
  - When `memory_data_valid`=1 in FILL: `write_data_array`=1, `fill_word`=`recv_cnt`[2:0], and `recv_cnt` increments.
  - Memory returns in order, so the k-th valid is word k.
  - Return may overlap issue (memory latency is 4 cycles) and may have gaps.
- Completion:
  - On the valid with `recv_cnt`==7, `write_data_array`=1 and `write_tag_array`=1 in the same cycle.
  - state←IDLE at that edge; `fsm_busy` deasserts the next cycle.
  - The cache then hits on the replayed access.
- Valid before issue: a `memory_data_valid` with `recv_cnt`≥`issue_cnt` cannot occur legally. The FSM still accepts it and counts it; it is not checked.
- Latency: with a 4-cycle memory, miss sampled at edge N → `memory_enable` cycles N+1..N+8, valids N+5..N+12, `write_tag_array` at cycle N+12, `fsm_busy` low from cycle N+13.
- Output timing:
  - All outputs are combinational from registered state, counters and `memory_data_valid`.
  - There is no combinational path from `miss_detected` to any output.

Decomposition:
- Shared package: FILL state encoding (IDLE=0, FILL=1), `WORDS_PER_BLOCK`, `BLOCK_OFFSET_BITS`=4.
- Sub-module `fill_counter`: 4-bit register with enable and synchronous clear, plus an incrementer. It is instantiated twice, for `issue_cnt` and `recv_cnt`.

Test Plan:
- Reset → all outputs 0, `fsm_busy`=0. Assert `rst` mid-FILL after 3 valids → IDLE next cycle; `write_tag_array` never pulses; the next miss restarts at word 0.
- `miss_detected`=1 with `miss_address`=0x1236, memory latency 4 → `memory_address` 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
  - `write_data_array` pulses 8 times with `fill_word` 0..7.
  - `write_tag_array`=1 only with the 8th write.
  - `fsm_busy` high for exactly 12 cycles.
- Valids with gaps, returning on cycles 5,6,9,10,11,14,15,16 after the miss → `fill_word` still 0..7 in order; `write_tag_array` at cycle 16; `fsm_busy` drops at cycle 17.
- `memory_data_valid` pulsed while in IDLE → no `write_data_array`; counters stay 0.
- `miss_detected` held high through FILL, then high again in the cycle after completion, with `miss_address`=0xFFF0 → a second fill starts; addresses 0xFFF0..0xFFFE with no wrap into the next block.
- `fill_data` equals `memory_data` on every cycle where `write_data_array`=1; check with data values 0xA000+k.
